fp_align_stage: RTL and testbench
=================================

// Module: fp_align_stage
// PURPOSE
// - Operand-alignment stage of the FP add/sub datapath; sits directly downstream of the exponent subtractor.
// - Takes two unpacked operands (exponent + mantissa with hidden bit) and orders them by exponent.
// - Right-shifts the smaller operand's mantissa by the exponent difference and appends guard/round/sticky bits.
// - 2-stage valid/ready pipeline. Feeds the mantissa add/sub and normalise stages.
// PARAMETERS
// - EXP_W  8   exponent width (biased, unsigned)
// - MAN_W  24  mantissa width including hidden bit
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        asynchronous active-low reset
// - in_valid   in   1        input operand pair valid
// - in_ready   out  1        stage can accept input this cycle
// - a_exp      in   EXP_W    operand A exponent
// - a_man      in   MAN_W    operand A mantissa
// - b_exp      in   EXP_W    operand B exponent
// - b_man      in   MAN_W    operand B mantissa
// - out_valid  out  1        aligned result valid
// - out_ready  in   1        downstream accepts result
// - out_exp    out  EXP_W    larger exponent (common exponent)
// - big_man    out  MAN_W    mantissa of the larger-exponent operand
// - small_man  out  MAN_W+3  aligned smaller mantissa {man, G, R, S}
// - swapped    out  1        1 = B had the larger exponent
// BEHAVIOUR
// - Reset (async, rst_n=0): out_valid=0, internal s1_valid=0; out_exp, big_man, small_man, swapped = 0. in_ready=1 once reset is released.
// - Stage 1 (compare):
//   - Two subtractor instances compute a_exp-b_exp and b_exp-a_exp.
//   - Borrow on a_exp-b_exp => swap=1 and diff=b_exp-a_exp; otherwise swap=0 and diff=a_exp-b_exp.
//   - Equal exponents => swap=0, diff=0. Mantissa magnitude is never compared.
//   - Registers swap, diff, max exponent, big and small mantissa.
// - Stage 2 (shift):
//   - ext = {small, 3'b000}; small_man = (ext >> diff) with bit0 |= OR of all bits shifted out (sticky).
//   - diff >= MAN_W+3 => small_man = {(MAN_W+2)'b0, |small}.
//   - Result is registered to the outputs.
// - Latency: exactly 2 cycles from input handshake to out_valid when out_ready is held 1. Throughput is 1 per cycle.
// - Handshake:
//   - Transfer occurs when valid && ready. Inputs are sampled only on in_valid && in_ready.
//   - s2_adv = !out_valid || out_ready.
//   - s1_adv = !s1_valid || s2_adv.
//   - in_ready = s1_adv. in_ready is combinational from out_ready; there is no skid buffer.
//   - While out_valid && !out_ready, all outputs hold stable.
//   - Pipeline holds at most 2 items. Order is preserved; no drops, no duplicates.
// - Simultaneous events:
//   - Output consumed and new input accepted in the same cycle => both stages advance.
//   - Stage 1 empty while stage 2 is consumed => out_valid falls to 0 next cycle.
// - Reset mid-operation flushes both stages immediately. In-flight items are discarded, not replayed.
// - Width rules: diff is EXP_W bits, unsigned. No exponent overflow is possible (the max exponent is passed through unchanged).
// STRUCTURE
// - Shared package fp_pkg holds:
//   - EXP_W and MAN_W defaults.
//   - GRS_W = 3.
//   - typedef struct fp_unpacked_t {exp, man}.
// - Sub-modules:
//   - subtractor #(.SIZE(EXP_W)) x2 for the exponent differences.
//   - fp_sticky_shifter #(.W(MAN_W+3), .SH_W(EXP_W)): combinational right shift with sticky OR, used in stage 2.
// - Top level holds only the pipeline registers, swap muxing and handshake logic.
// TESTING
// All cases use defaults EXP_W=8, MAN_W=24; out_ready=1 unless stated.
// - Basic shift: a_exp=130, a_man=0xC00000, b_exp=128, b_man=0x800000 -> after 2 cycles: out_exp=130, big_man=0xC00000, small_man=0x1000000, swapped=0.
// - Swap + sticky: a_exp=100, a_man=0x800001, b_exp=104, b_man=0xA00000 -> out_exp=104, big_man=0xA00000, swapped=1, small_man=0x400001.
// - Saturated shift: a_exp=200, a_man=0x800000, b_exp=10, b_man=0x800000 (diff 190) -> small_man=27'h1. Same with b_man=0 -> small_man=0.
// - Equal exponents: a_exp=b_exp=127, a_man=0x800000, b_man=0xFFFFFF -> swapped=0, big_man=0x800000, small_man={0xFFFFFF,3'b000}.
// - Backpressure: 4 back-to-back inputs with out_ready=0 for 6 cycles -> in_ready=0 after 2 accepted. Outputs stay stable. Release yields 4 results in order with no gaps.
// - Reset mid-flight: assert rst_n=0 with both stages full -> out_valid=0 asynchronously. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP datapath constants and the unpacked operand type.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 24;
  localparam int GRS_W    = 3;

  typedef struct packed {
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_sticky_shifter.sv
// Combinational right shifter that ORs every bit shifted out into bit 0.
module fp_sticky_shifter #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] sh,
  output logic [W-1:0]    dout
);

  logic [W-1:0] ones;
  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;

  // Shift, then fold the discarded low bits into the sticky position;
  // shifts of W or more collapse the whole input into the sticky bit.
  always_comb begin
    ones      = '1;
    shifted   = din >> sh;
    lost_mask = ~(ones << sh);
    if (32'(sh) >= W) begin
      dout = {{(W-1){1'b0}}, |din};
    end else begin
      dout = {shifted[W-1:1], shifted[0] | (|(din & lost_mask))};
    end
  end

endmodule

// File: rtl/subtractor.sv
// Unsigned subtractor with borrow-out; used for exponent differences.
module subtractor #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] diff,
  output logic            borrow
);

  // One extra bit on the left captures the borrow of a - b.
  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/fp_align_stage.sv
// FP add/sub operand alignment: exponent compare/swap, then sticky right
// shift of the smaller mantissa. Two-stage valid/ready pipeline.
module fp_align_stage
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W-1:0]       a_exp,
  input  logic [MAN_W-1:0]       a_man,
  input  logic [EXP_W-1:0]       b_exp,
  input  logic [MAN_W-1:0]       b_man,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       out_exp,
  output logic [MAN_W-1:0]       big_man,
  output logic [MAN_W+GRS_W-1:0] small_man,
  output logic                   swapped
);

  localparam int SM_W = MAN_W + GRS_W;

  logic [EXP_W-1:0] diff_ab, diff_ba;
  logic             borrow_ab, borrow_ba;
  logic             swap_c;
  logic             s2_adv, s1_adv, in_fire;
  logic [SM_W-1:0]  shift_out;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_swap_q,  s1_swap_d;
  logic [EXP_W-1:0] s1_diff_q,  s1_diff_d;
  logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
  logic [MAN_W-1:0] s1_big_q,   s1_big_d;
  logic [MAN_W-1:0] s1_small_q, s1_small_d;

  logic             out_valid_q, out_valid_d;
  logic [EXP_W-1:0] out_exp_q,   out_exp_d;
  logic [MAN_W-1:0] big_man_q,   big_man_d;
  logic [SM_W-1:0]  small_man_q, small_man_d;
  logic             swapped_q,   swapped_d;

  subtractor #(.SIZE(EXP_W)) u_sub_ab (
    .a      (a_exp),
    .b      (b_exp),
    .diff   (diff_ab),
    .borrow (borrow_ab)
  );

  subtractor #(.SIZE(EXP_W)) u_sub_ba (
    .a      (b_exp),
    .b      (a_exp),
    .diff   (diff_ba),
    .borrow (borrow_ba)
  );

  fp_sticky_shifter #(.W(SM_W), .SH_W(EXP_W)) u_shift (
    .din  ({s1_small_q, {GRS_W{1'b0}}}),
    .sh   (s1_diff_q),
    .dout (shift_out)
  );

  // Handshake: each stage advances when the stage after it can take data.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
    in_fire  = in_valid && s1_adv;
  end

  // Stage 1: order operands by exponent; equal exponents never swap.
  always_comb begin
    // A borrow on a-b alone implies b > a; ANDing the reverse no-borrow is
    // redundant but keeps both subtractors in the decision.
    swap_c     = borrow_ab && !borrow_ba;
    s1_valid_d = s1_valid_q;
    s1_swap_d  = s1_swap_q;
    s1_diff_d  = s1_diff_q;
    s1_exp_d   = s1_exp_q;
    s1_big_d   = s1_big_q;
    s1_small_d = s1_small_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_swap_d  = swap_c;
      s1_diff_d  = swap_c ? diff_ba : diff_ab;
      s1_exp_d   = swap_c ? b_exp   : a_exp;
      s1_big_d   = swap_c ? b_man   : a_man;
      s1_small_d = swap_c ? a_man   : b_man;
    end
  end

  // Stage 2: register the aligned result; hold everything while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_exp_d   = out_exp_q;
    big_man_d   = big_man_q;
    small_man_d = small_man_q;
    swapped_d   = swapped_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_exp_d   = s1_exp_q;
        big_man_d   = s1_big_q;
        small_man_d = shift_out;
        swapped_d   = s1_swap_q;
      end
    end
  end

  // Pipeline registers; reset flushes both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_swap_q   <= 1'b0;
      s1_diff_q   <= '0;
      s1_exp_q    <= '0;
      s1_big_q    <= '0;
      s1_small_q  <= '0;
      out_valid_q <= 1'b0;
      out_exp_q   <= '0;
      big_man_q   <= '0;
      small_man_q <= '0;
      swapped_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_swap_q   <= s1_swap_d;
      s1_diff_q   <= s1_diff_d;
      s1_exp_q    <= s1_exp_d;
      s1_big_q    <= s1_big_d;
      s1_small_q  <= s1_small_d;
      out_valid_q <= out_valid_d;
      out_exp_q   <= out_exp_d;
      big_man_q   <= big_man_d;
      small_man_q <= small_man_d;
      swapped_q   <= swapped_d;
    end
  end

  // Drive outputs straight from the stage-2 registers.
  always_comb begin
    out_valid = out_valid_q;
    out_exp   = out_exp_q;
    big_man   = big_man_q;
    small_man = small_man_q;
    swapped   = swapped_q;
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed cases, backpressure,
// reset mid-flight and randomized traffic against a scoreboard model.
module tb_fp_align_stage;
  import fp_pkg::*;

  localparam int EW = FP_EXP_W;
  localparam int MW = FP_MAN_W;
  localparam int SW = MW + GRS_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] a_exp = '0;
  logic [MW-1:0] a_man = '0;
  logic [EW-1:0] b_exp = '0;
  logic [MW-1:0] b_man = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] big_man;
  logic [SW-1:0] small_man;
  logic          swapped;

  fp_align_stage #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_exp     (a_exp),
    .a_man     (a_man),
    .b_exp     (b_exp),
    .b_man     (b_man),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .big_man   (big_man),
    .small_man (small_man),
    .swapped   (swapped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  typedef struct {
    longint unsigned e;
    longint unsigned big;
    longint unsigned sm;
    bit              sw;
  } res_t;

  // Reference: pick the larger exponent, scale the smaller mantissa by
  // 2^-diff in integer arithmetic, and set the sticky bit on any remainder.
  function automatic res_t model(input fp_unpacked_t a, input fp_unpacked_t b);
    res_t            r;
    longint unsigned s, ext, d, p;
    if (b.exp > a.exp) begin
      r.sw = 1'b1; r.e = b.exp; r.big = b.man; s = a.man; d = b.exp - a.exp;
    end else begin
      r.sw = 1'b0; r.e = a.exp; r.big = a.man; s = b.man; d = a.exp - b.exp;
    end
    ext = s * 8;
    if (d >= SW) begin
      r.sm = (s != 0) ? 1 : 0;
    end else begin
      p    = longint'(1) << d;
      r.sm = ext / p;
      if ((ext % p) != 0) r.sm = r.sm | 1;
    end
    return r;
  endfunction

  res_t q[$];
  res_t r;
  res_t prev;
  bit   prev_stall = 1'b0;

  // Scoreboard: model every accepted input, match every consumed output
  // in order, and require outputs to hold while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_exp",   64'(out_exp),   64'(prev.e));
        chk("stall_big",   64'(big_man),   64'(prev.big));
        chk("stall_small", 64'(small_man), 64'(prev.sm));
        chk("stall_swap",  64'(swapped),   64'(prev.sw));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(q.size()), 64'd1);
        end else begin
          r = q.pop_front();
          chk("sb_exp",   64'(out_exp),   64'(r.e));
          chk("sb_big",   64'(big_man),   64'(r.big));
          chk("sb_small", 64'(small_man), 64'(r.sm));
          chk("sb_swap",  64'(swapped),   64'(r.sw));
        end
      end
      if (in_valid && in_ready) q.push_back(model({a_exp, a_man}, {b_exp, b_man}));
      prev_stall = out_valid && !out_ready;
      prev.e     = out_exp;
      prev.big   = big_man;
      prev.sm    = small_man;
      prev.sw    = swapped;
    end
  end

  task automatic apply_check(input string tag,
                             input logic [EW-1:0] ae, input logic [MW-1:0] am,
                             input logic [EW-1:0] be, input logic [MW-1:0] bm,
                             input logic [EW-1:0] x_exp, input logic [MW-1:0] x_big,
                             input logic [SW-1:0] x_sm, input logic x_sw);
    @(posedge clk); #1;
    out_ready = 1'b1;
    a_exp = ae; a_man = am; b_exp = be; b_man = bm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_exp"},   64'(out_exp),   64'(x_exp));
    chk({tag, "_big"},   64'(big_man),   64'(x_big));
    chk({tag, "_small"}, 64'(small_man), 64'(x_sm));
    chk({tag, "_swap"},  64'(swapped),   64'(x_sw));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [EW-1:0] bp_ae [4];
    logic [MW-1:0] bp_am [4];
    logic [EW-1:0] bp_be [4];
    logic [MW-1:0] bp_bm [4];
    int            idx;
    int            waited;

    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_exp",   64'(out_exp),   64'd0);
    chk("rst_big",       64'(big_man),   64'd0);
    chk("rst_small",     64'(small_man), 64'd0);
    chk("rst_swap",      64'(swapped),   64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    apply_check("basic", 8'd130, 24'hC00000, 8'd128, 24'h800000,
                8'd130, 24'hC00000, 27'h1000000, 1'b1 ^ 1'b1);
    apply_check("swap",  8'd100, 24'h800001, 8'd104, 24'hA00000,
                8'd104, 24'hA00000, 27'h400001, 1'b1);
    apply_check("sat",   8'd200, 24'h800000, 8'd10,  24'h800000,
                8'd200, 24'h800000, 27'h1, 1'b0);
    apply_check("sat0",  8'd200, 24'h800000, 8'd10,  24'h000000,
                8'd200, 24'h800000, 27'h0, 1'b0);
    apply_check("eq",    8'd127, 24'h800000, 8'd127, 24'hFFFFFF,
                8'd127, 24'h800000, {24'hFFFFFF, 3'b000}, 1'b0);

    // Backpressure: stall output for 6 cycles, then release.
    for (int i = 0; i < 4; i++) begin
      bp_ae[i] = EW'($urandom); bp_am[i] = {1'b1, 23'($urandom)};
      bp_be[i] = EW'($urandom); bp_bm[i] = {1'b1, 23'($urandom)};
    end
    @(posedge clk); #1;
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      out_ready = (cyc >= 6);
      if (idx < 4) begin
        in_valid = 1'b1;
        a_exp = bp_ae[idx]; a_man = bp_am[idx]; b_exp = bp_be[idx]; b_man = bp_bm[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 5) begin
        chk("bp_accepted",  64'(idx),       64'd2);
        chk("bp_in_ready",  64'(in_ready),  64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      if (cyc >= 6 && cyc <= 9) chk("bp_no_gap", 64'(out_valid), 64'd1);
      if (in_valid && in_ready) idx++;
    end
    chk("bp_all_sent", 64'(idx), 64'd4);

    // Reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a_exp = 8'd50; a_man = 24'h812345; b_exp = 8'd40; b_man = 24'hF00001;
    @(posedge clk); #1;
    a_exp = 8'd60; a_man = 24'h900000; b_exp = 8'd70; b_man = 24'hABCDEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_in_ready", 64'(in_ready),  64'd0);
    chk("mid_full_valid",    64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_exp",   64'(out_exp),   64'd0);
    chk("mid_rst_small", 64'(small_man), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with random backpressure.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_exp = EW'($urandom);
      case ($urandom_range(0, 2))
        0:       b_exp = EW'($urandom);
        1:       b_exp = a_exp + EW'($urandom_range(0, 30)) - EW'(15);
        default: b_exp = a_exp;
      endcase
      a_man = ($urandom_range(0, 9) == 0) ? MW'($urandom) : {1'b1, 23'($urandom)};
      b_man = ($urandom_range(0, 9) == 0) ? '0 : {1'b1, 23'($urandom)};
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
    chk("drain_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
